// File: rtl/fpmul_pkg.sv
// fpmul_pkg -- shared definitions for the vector FP32 multiply controller.
//   FSM state encoding, FP32 field widths, exponent bias, canonical NaN and
//   infinity constants, and the multiplier response struct.
//   Build option: FPMUL_RNE_EN selects round-to-nearest-even in fp32_mul_pipe
//   (truncation otherwise); nothing in this package depends on it.
package fpmul_pkg;

  // Controller states. The enum names the encoding; the ST_* constants are the
  // legacy-compatible vector form the FSM actually switches on.
  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_RUN   = 2'd1,
    FSM_DRAIN = 2'd2,
    FSM_DONE  = 2'd3
  } fsm_e;

  localparam logic [1:0] ST_IDLE  = FSM_IDLE;
  localparam logic [1:0] ST_RUN   = FSM_RUN;
  localparam logic [1:0] ST_DRAIN = FSM_DRAIN;
  localparam logic [1:0] ST_DONE  = FSM_DONE;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  // 10-bit signed exponent arithmetic covers ea+eb-127 plus two increments.
  localparam logic signed [9:0] FP_BIAS    = 10'sd127;
  localparam logic signed [9:0] FP_EXP_MAX = 10'sd255;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } fpmul_rsp_t;

endpackage

// File: rtl/vec_fpmul_ctrl_if.sv
// vec_fpmul_ctrl_if -- host bus of the vector FP32 multiply controller.
//   master (host): start, ld_en/ld_sel/ld_addr/ld_data operand writes,
//                  rd_addr result index; sees rd_data, rd_flag, busy, done,
//                  exc_any.
//   slave  (controller): the mirror image.
interface vec_fpmul_ctrl_if #(
  parameter int AW = 5
);
  logic          start;
  logic          ld_en;
  logic          ld_sel;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic [1:0]    rd_flag;
  logic          busy;
  logic          done;
  logic          exc_any;

  modport master (
    output start, ld_en, ld_sel, ld_addr, ld_data, rd_addr,
    input  rd_data, rd_flag, busy, done, exc_any
  );

  modport slave (
    input  start, ld_en, ld_sel, ld_addr, ld_data, rd_addr,
    output rd_data, rd_flag, busy, done, exc_any
  );
endinterface

// File: rtl/fp32_mul_pipe.sv
// fp32_mul_pipe -- IEEE-754 single multiply, fixed PIPE_LAT-cycle latency.
//   clk   : clock, rising edge
//   a_i   : operand A (FP32)
//   b_i   : operand B (FP32)
//   rsp_o : {result, ovf, unf}, valid PIPE_LAT edges after a_i/b_i
//   No handshake and no reset: the caller tracks validity alongside.
//   Denormals flush to signed zero. FPMUL_RNE_EN defined: round to nearest
//   even with guard/round/sticky; undefined: truncate. Latency is identical.
module fp32_mul_pipe
  import fpmul_pkg::*;
#(
  parameter int PIPE_LAT = 3
) (
  input  logic        clk,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output fpmul_rsp_t  rsp_o
);

  logic                sa, sb, sgn;
  logic [FP_EXP_W-1:0] ea, eb;
  logic [FP_MAN_W-1:0] ma, mb;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]         prod;
  logic signed [9:0]   exp_sum, exp_n, exp_f;
  logic [FP_MAN_W-1:0] man, man_r;
  fpmul_rsp_t          rsp_c;
`ifdef FPMUL_RNE_EN
  logic                grd, stk, rnd_up;
  logic [FP_MAN_W:0]   man_sum;
`else
  logic                unused_prod_lo;
  assign unused_prod_lo = ^prod[22:0];
`endif

  always_comb begin
    sa = a_i[31];
    sb = b_i[31];
    ea = a_i[FP_MAN_W +: FP_EXP_W];
    eb = b_i[FP_MAN_W +: FP_EXP_W];
    ma = a_i[FP_MAN_W-1:0];
    mb = b_i[FP_MAN_W-1:0];
    sgn = sa ^ sb;

    // Exponent 0 covers both true zero and denormals (flushed).
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (ma == '0);
    b_inf  = (eb == '1) && (mb == '0);
    a_nan  = (ea == '1) && (ma != '0);
    b_nan  = (eb == '1) && (mb != '0);

    prod    = 48'({1'b1, ma}) * 48'({1'b1, mb});
    exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - FP_BIAS;

    // Product of two [1,2) significands lies in [1,4); bit 47 means >= 2.
    if (prod[47]) begin
      man   = prod[46:24];
      exp_n = exp_sum + 10'sd1;
    end else begin
      man   = prod[45:23];
      exp_n = exp_sum;
    end

`ifdef FPMUL_RNE_EN
    grd     = prod[47] ? prod[23] : prod[22];
    stk     = prod[47] ? (|prod[22:0]) : (|prod[21:0]);
    rnd_up  = grd & (stk | man[0]);
    man_sum = {1'b0, man} + {{FP_MAN_W{1'b0}}, rnd_up};
    man_r   = man_sum[FP_MAN_W-1:0];
    // Carry-out means the mantissa rolled to 2.0: fraction is already zero.
    exp_f   = man_sum[FP_MAN_W] ? exp_n + 10'sd1 : exp_n;
`else
    man_r = man;
    exp_f = exp_n;
`endif

    rsp_c = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      rsp_c.res = FP_QNAN;
    end else if (a_inf || b_inf) begin
      rsp_c.res = FP_INF | {sgn, 31'd0};
    end else if (a_zero || b_zero) begin
      rsp_c.res = {sgn, 31'd0};
    end else if (exp_f >= FP_EXP_MAX) begin
      rsp_c.res = FP_INF | {sgn, 31'd0};
      rsp_c.ovf = 1'b1;
    end else if (exp_f <= 10'sd0) begin
      rsp_c.res = {sgn, 31'd0};
      rsp_c.unf = 1'b1;
    end else begin
      rsp_c.res = {sgn, exp_f[FP_EXP_W-1:0], man_r};
    end
  end

  // Result computed in front of the first register, then delayed so that the
  // output lines up with the caller's PIPE_LAT-deep valid shift register.
  fpmul_rsp_t pipe_q [PIPE_LAT];

  always_ff @(posedge clk) begin
    pipe_q[0] <= rsp_c;
    for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign rsp_o = pipe_q[PIPE_LAT-1];

endmodule

// File: rtl/vec_fpmul_ctrl.sv
// vec_fpmul_ctrl -- element-wise FP32 vector multiply R = A * B.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : vec_fpmul_ctrl_if.slave
//           start   - level, sampled in IDLE/DONE to launch
//           ld_*    - operand writes (A bank when ld_sel=0, B bank when 1),
//                     dropped while busy
//           rd_addr - result index; rd_data/rd_flag read combinationally
//           busy    - RUN or DRAIN; done - DONE (held until next start)
//           exc_any - OR of {ovf,unf} of every writeback since launch
//   One element issues per cycle in RUN; element k is written PIPE_LAT+1
//   edges after its issue cycle begins. Operand/result banks are not reset.
//   Build option: FPMUL_RNE_EN (rounding mode of fp32_mul_pipe).
module vec_fpmul_ctrl
  import fpmul_pkg::*;
#(
  parameter int VLEN     = 32,
  parameter int PIPE_LAT = 3
) (
  input logic             clk,
  input logic             reset,
  vec_fpmul_ctrl_if.slave bus
);

  localparam int AW = $clog2(VLEN);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          exc_q, exc_d;
  logic          busy, issue_vld, wb_vld;
  logic [AW-1:0] wb_idx;

  // Element tracking alongside the data pipe: stage i holds the element that
  // issued i cycles ago.
  logic [PIPE_LAT:1]         vld_pipe;
  logic [PIPE_LAT:1][AW-1:0] idx_pipe;

  logic [31:0] a_bank [VLEN];
  logic [31:0] b_bank [VLEN];
  logic [31:0] r_bank [VLEN];
  logic [1:0]  f_bank [VLEN];

  fpmul_rsp_t rsp;

  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign issue_vld = (state_q == ST_RUN);
  assign wb_vld    = vld_pipe[PIPE_LAT];
  assign wb_idx    = idx_pipe[PIPE_LAT];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exc_d   = exc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          exc_d   = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(VLEN - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Empty pipe here means the last writeback happened on the previous
        // edge, so DONE lands one cycle after it.
        if (vld_pipe == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Launch only happens with an empty pipe, so this never races the clear.
    if (wb_vld && (rsp.ovf || rsp.unf)) exc_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      exc_q    <= 1'b0;
      vld_pipe <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exc_q    <= exc_d;
      vld_pipe <= {vld_pipe[PIPE_LAT-1:1], issue_vld};
    end
  end

  always_ff @(posedge clk) begin
    idx_pipe <= {idx_pipe[PIPE_LAT-1:1], cnt_q};
  end

  // Banks are plain storage. Operand writes are locked out while busy so the
  // in-flight operation always sees a stable A/B.
  always_ff @(posedge clk) begin
    if (bus.ld_en && !busy) begin
      if (bus.ld_sel) b_bank[bus.ld_addr] <= bus.ld_data;
      else            a_bank[bus.ld_addr] <= bus.ld_data;
    end
    if (wb_vld) begin
      r_bank[wb_idx] <= rsp.res;
      f_bank[wb_idx] <= {rsp.ovf, rsp.unf};
    end
  end

  fp32_mul_pipe #(
    .PIPE_LAT(PIPE_LAT)
  ) u_mul (
    .clk  (clk),
    .a_i  (a_bank[cnt_q]),
    .b_i  (b_bank[cnt_q]),
    .rsp_o(rsp)
  );

  assign bus.rd_data = r_bank[bus.rd_addr];
  assign bus.rd_flag = f_bank[bus.rd_addr];
  assign bus.busy    = busy;
  assign bus.done    = (state_q == ST_DONE);
  assign bus.exc_any = exc_q;

endmodule

// File: tb/tb_vec_fpmul_ctrl.sv
// tb_vec_fpmul_ctrl -- directed sequence with randomized operands for
// vec_fpmul_ctrl (VLEN=32, PIPE_LAT=3), checked against a value-level FP32
// multiply model. Honours FPMUL_RNE_EN to pick the rounding mode.
module tb_vec_fpmul_ctrl;
  localparam int VLEN     = 32;
  localparam int PIPE_LAT = 3;
  localparam int AW       = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vec_fpmul_ctrl_if #(.AW(AW)) bus ();

  vec_fpmul_ctrl #(
    .VLEN(VLEN),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] opa [VLEN];
  logic [31:0] opb [VLEN];
  logic [31:0] exp_r [VLEN];
  logic [1:0]  exp_f [VLEN];
  logic [31:0] prev_r [VLEN];

  // Reference: value = sig * 2^(e-150) per operand; product significand P is
  // normalised by locating its leading one, then rounded on the dropped bits.
  function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, p, sh, fld;
    longint ma, mb, pr, q;
    bit az, bz, ai, bi, an, bn;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (ma == 0);
    bi = (eb == 255) && (mb == 0);
    an = (ea == 255) && (ma != 0);
    bn = (eb == 255) && (mb != 0);
    if (an || bn || (ai && bz) || (bi && az)) return {2'b00, 32'h7FC00000};
    if (ai || bi) return {2'b00, s, 8'hFF, 23'd0};
    if (az || bz) return {2'b00, s, 31'd0};
    pr = (ma + 64'd8388608) * (mb + 64'd8388608);
    p = 47;
    while (pr[p] == 1'b0) p--;
    sh  = p - 23;
    q   = pr >> sh;
    fld = ea + eb + p - 173;
`ifdef FPMUL_RNE_EN
    begin
      longint rem, half;
      rem  = pr - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        fld = fld + 1;
      end
    end
`endif
    if (fld >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (fld <= 0)   return {2'b01, s, 31'd0};
    return {2'b00, s, fld[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    int          c;
    c = int'($urandom_range(0, 15));
    s = 1'($urandom);
    m = 23'($urandom);
    case (c)
      0:       e = 8'd0;
      1:       begin e = 8'hFF; m = '0; end
      2:       begin e = 8'hFF; m = m | 23'd1; end
      3, 4:    e = 8'($urandom_range(190, 254));
      5, 6:    e = 8'($urandom_range(1, 70));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {s, e, m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < VLEN; i++) begin
      bus.ld_en = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = AW'(i); bus.ld_data = opa[i];
      tick();
      bus.ld_sel = 1'b1; bus.ld_data = opb[i];
      tick();
    end
    bus.ld_en = 1'b0;
  endtask

  task automatic model();
    logic [33:0] t;
    for (int i = 0; i < VLEN; i++) begin
      t = ref_mul(opa[i], opb[i]);
      exp_f[i] = t[33:32];
      exp_r[i] = t[31:0];
    end
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < VLEN; i++) begin
      opa[i] = rand_op();
      opb[i] = rand_op();
    end
  endtask

  task automatic launch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int idx, input logic [31:0] exp);
    bus.rd_addr = AW'(idx);
    #1;
    chk(tag, bus.rd_data, exp);
  endtask

  task automatic check_all(input string tag);
    logic ex;
    ex = 1'b0;
    for (int i = 0; i < VLEN; i++) begin
      bus.rd_addr = AW'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), bus.rd_data, exp_r[i]);
      chk($sformatf("%s_f%0d", tag, i), {30'd0, bus.rd_flag}, {30'd0, exp_f[i]});
      ex = ex | (|exp_f[i]);
    end
    chk($sformatf("%s_exc_any", tag), {31'd0, bus.exc_any}, {31'd0, ex});
  endtask

  initial begin
    bus.start = 1'b0; bus.ld_en = 1'b0; bus.ld_sel = 1'b0;
    bus.ld_addr = '0; bus.ld_data = '0; bus.rd_addr = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_exc",  {31'd0, bus.exc_any}, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Run 1: directed elements 0..2, random rest; writes/start during RUN
    randomize_ops();
    opa[0] = 32'h3FC00000; opb[0] = 32'h40000000;
    opa[1] = 32'h7F000000; opb[1] = 32'h40000000;
    opa[2] = 32'h3FC00001; opb[2] = 32'h3FC00001;
    load_all();
    model();
    launch();                                   // t = 0
    chk("r1_busy_t0", {31'd0, bus.busy}, 32'd1);
    chk("r1_done_t0", {31'd0, bus.done}, 32'd0);
    repeat (4) tick();                          // t = 4
    bus.ld_en = 1'b1; bus.ld_sel = 1'b0; bus.ld_addr = AW'(3);
    bus.ld_data = opa[3] ^ 32'h00400000;
    bus.start = 1'b1;
    tick();                                     // t = 5
    bus.ld_en = 1'b0; bus.start = 1'b0;
    chk("r1_busy_mid", {31'd0, bus.busy}, 32'd1);
    repeat (30) tick();                         // t = 35
    chk("r1_done_t35", {31'd0, bus.done}, 32'd0);
    chk("r1_busy_t35", {31'd0, bus.busy}, 32'd1);
    tick();                                     // t = 36
    chk("r1_done_t36", {31'd0, bus.done}, 32'd1);
    chk("r1_busy_t36", {31'd0, bus.busy}, 32'd0);
    check_all("r1");
    rd_chk("r1_dir0", 0, 32'h40400000);
    rd_chk("r1_dir1", 1, 32'h7F800000);
    chk("r1_dir1_flag", {30'd0, bus.rd_flag}, 32'd2);
`ifdef FPMUL_RNE_EN
    rd_chk("r1_dir2", 2, 32'h40100002);
`else
    rd_chk("r1_dir2", 2, 32'h40100001);
`endif
    chk("r1_exc_dir", {31'd0, bus.exc_any}, 32'd1);
    repeat (3) tick();
    chk("r1_done_held", {31'd0, bus.done}, 32'd1);

    // Run 2: fresh operands, launch from DONE, read-before-writeback in DRAIN
    for (int i = 0; i < VLEN; i++) prev_r[i] = exp_r[i];
    randomize_ops();
    load_all();
    model();
    launch();                                   // t = 0
    chk("r2_done_drop", {31'd0, bus.done}, 32'd0);
    chk("r2_busy_t0", {31'd0, bus.busy}, 32'd1);
    chk("r2_exc_clr", {31'd0, bus.exc_any}, 32'd0);
    repeat (33) tick();                         // t = 33, DRAIN
    chk("r2_busy_drain", {31'd0, bus.busy}, 32'd1);
    rd_chk("r2_old31", 31, prev_r[31]);
    rd_chk("r2_new0", 0, exp_r[0]);
    repeat (2) tick();                          // t = 35
    chk("r2_done_t35", {31'd0, bus.done}, 32'd0);
    tick();                                     // t = 36
    chk("r2_done_t36", {31'd0, bus.done}, 32'd1);
    check_all("r2");

    // Run 3: reset mid-run, then restart
    for (int i = 0; i < VLEN; i++) prev_r[i] = exp_r[i];
    randomize_ops();
    load_all();
    model();
    launch();                                   // t = 0
    repeat (10) tick();                         // t = 10
    reset = 1'b0;
    #1;
    chk("rst_run_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_run_done", {31'd0, bus.done}, 32'd0);
    chk("rst_run_exc",  {31'd0, bus.exc_any}, 32'd0);
    tick();
    chk("rst_hold_busy", {31'd0, bus.busy}, 32'd0);
    rd_chk("rst_wr6", 6, exp_r[6]);
    rd_chk("rst_drop7", 7, prev_r[7]);
    reset = 1'b1;
    tick();
    launch();                                   // t = 0
    repeat (35) tick();                         // t = 35
    chk("r3_done_t35", {31'd0, bus.done}, 32'd0);
    tick();                                     // t = 36
    chk("r3_done_t36", {31'd0, bus.done}, 32'd1);
    check_all("r3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
